// File: rtl/hsv_select_pack_pkg.sv
// Shared float-field types and constants for the HSV select/pack stage.
// Consumers import hsv_pkg::*.
package hsv_pkg;

    localparam logic [7:0]  F32_EXP_BIAS  = 8'd127;
    localparam logic [31:0] F32_HUE_B_OFS = 32'h432B0000;
    localparam logic [31:0] F32_HUE_G_OFS = 32'h42AA0000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } f32_t;

    typedef struct packed {
        logic [7:0] h;
        logic [7:0] s;
        logic [7:0] v;
    } hsv8_t;

    // All-ones exponent covers both NaN and infinity.
    function automatic logic f32_is_special(input f32_t x);
        return (x.exp == 8'hFF);
    endfunction

endpackage

// File: rtl/hsv_select_pack_if.sv
// Upstream and downstream handshake bundle of hsv_select_pack.
// The slave modport is the block's view; the master modport is the driver's view.
interface hsv_select_pack_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] t4;
    logic [31:0] t5;
    logic [31:0] t6;
    logic [31:0] s34;
    logic [31:0] v34;
    logic        Max_R34;
    logic        Max_G34;
    logic        Max_B34;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  h_out;
    logic [7:0]  s_out;
    logic [7:0]  v_out;

    modport slave (
        input  in_valid, t4, t5, t6, s34, v34, Max_R34, Max_G34, Max_B34, out_ready,
        output in_ready, out_valid, h_out, s_out, v_out
    );

    modport master (
        output in_valid, t4, t5, t6, s34, v34, Max_R34, Max_G34, Max_B34, out_ready,
        input  in_ready, out_valid, h_out, s_out, v_out
    );
endinterface

// File: rtl/hsv_select_pack_f32_to_u8.sv
// IEEE-754 single to 8-bit unsigned converter; WRAP selects modulo-256 hue
// behaviour, ROUND selects round-half-away versus truncation. Output is unregistered.
module f32_to_u8
    import hsv_pkg::*;
#(
    parameter bit WRAP  = 1'b0,
    parameter bit ROUND = 1'b1
) (
    input  f32_t       x,
    output logic [7:0] y
);

    logic [23:0] sig_s;
    logic [7:0]  shamt_s;
    logic [23:0] val2_s;
    logic [23:0] mag_s;

    // Magnitude in fixed point with one fractional bit, then rounded or truncated.
    always_comb begin
        sig_s   = {1'b1, x.mant};
        shamt_s = 8'd149 - x.exp;
        val2_s  = sig_s >> shamt_s;
        if (ROUND) begin
            mag_s = (val2_s + 24'd1) >> 1;
        end else begin
            mag_s = val2_s >> 1;
        end
    end

    // Range classification; the shifter is only meaningful for 0.5 <= |x| < 2^15.
    always_comb begin
        y = 8'd0;
        if (x.exp == 8'hFF) begin
            if (!WRAP && !x.sign && (x.mant == 23'd0)) begin
                y = 8'd255;
            end else begin
                y = 8'd0;
            end
        end else if (x.exp < (F32_EXP_BIAS - 8'd1)) begin
            y = 8'd0;
        end else if (x.exp >= (F32_EXP_BIAS + 8'd15)) begin
            y = (!WRAP && !x.sign) ? 8'd255 : 8'd0;
        end else if (WRAP) begin
            y = x.sign ? (~mag_s[7:0] + 8'd1) : mag_s[7:0];
        end else if (x.sign) begin
            y = 8'd0;
        end else if (mag_s > 24'd255) begin
            y = 8'd255;
        end else begin
            y = mag_s[7:0];
        end
    end

endmodule

// File: rtl/hsv_select_pack.sv
// Final RGB->HSV stage: hue select by max channel, then float->u8 pack, two
// registered stages with valid/ready. Optional sticky err_flag under `HSV_PACK_ERR_EN.
module hsv_select_pack
    import hsv_pkg::*;
#(
    parameter bit HUE_WRAP   = 1'b1,
    parameter bit FRAC_ROUND = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    hsv_select_pack_if.slave   bus
`ifdef HSV_PACK_ERR_EN
    ,
    output logic               err_flag
`endif
);

    logic       rdy_en_r;
    logic       s1_valid_r;
    f32_t       s1_hue_r;
    f32_t       s1_s_r;
    f32_t       s1_v_r;
    logic       s2_valid_r;
    hsv8_t      s2_pix_r;
    logic       s2_adv_s;
    f32_t       hue_sel_s;
    logic [7:0] conv_h_s;
    logic [7:0] conv_s_s;
    logic [7:0] conv_v_s;

    // Hue candidate by max channel, R over G over B; no flag falls back to t5.
    always_comb begin
        hue_sel_s = f32_t'(bus.t5);
        if (bus.Max_R34) begin
            hue_sel_s = f32_t'(bus.t5);
        end else if (bus.Max_G34) begin
            hue_sel_s = f32_t'(bus.t6);
        end else if (bus.Max_B34) begin
            hue_sel_s = f32_t'(bus.t4);
        end else begin
            hue_sel_s = f32_t'(bus.t5);
        end
    end

    // Stage 2 frees a slot when empty or when downstream takes its bundle.
    assign s2_adv_s     = !s2_valid_r || bus.out_ready;
    assign bus.in_ready = rdy_en_r && (!s1_valid_r || s2_adv_s);

    // Holds in_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_r <= 1'b0;
        end else begin
            rdy_en_r <= 1'b1;
        end
    end

    // Stage 1 register: selected hue plus raw saturation/value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_hue_r   <= '0;
            s1_s_r     <= '0;
            s1_v_r     <= '0;
        end else if (bus.in_ready) begin
            s1_valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                s1_hue_r <= hue_sel_s;
                s1_s_r   <= f32_t'(bus.s34);
                s1_v_r   <= f32_t'(bus.v34);
            end
        end
    end

    f32_to_u8 #(.WRAP(HUE_WRAP), .ROUND(FRAC_ROUND)) u_cvt_h (.x(s1_hue_r), .y(conv_h_s));
    f32_to_u8 #(.WRAP(1'b0),     .ROUND(FRAC_ROUND)) u_cvt_s (.x(s1_s_r),   .y(conv_s_s));
    f32_to_u8 #(.WRAP(1'b0),     .ROUND(FRAC_ROUND)) u_cvt_v (.x(s1_v_r),   .y(conv_v_s));

    // Stage 2 register drives the outputs directly; data held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_pix_r   <= '0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_pix_r <= '{h: conv_h_s, s: conv_s_s, v: conv_v_s};
            end
        end
    end

    assign bus.out_valid = s2_valid_r;
    assign bus.h_out     = s2_pix_r.h;
    assign bus.s_out     = s2_pix_r.s;
    assign bus.v_out     = s2_pix_r.v;

`ifdef HSV_PACK_ERR_EN
    logic s1_flag_err_r;
    logic err_flag_r;
    logic one_hot_s;
    logic special_s;

    assign one_hot_s = (bus.Max_R34 ^ bus.Max_G34 ^ bus.Max_B34)
                     && !(bus.Max_R34 && bus.Max_G34 && bus.Max_B34);
    assign special_s = f32_is_special(s1_hue_r) || f32_is_special(s1_s_r)
                     || f32_is_special(s1_v_r);

    // Flag-count error travels with the bundle through stage 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_flag_err_r <= 1'b0;
        end else if (bus.in_ready && bus.in_valid) begin
            s1_flag_err_r <= !one_hot_s;
        end
    end

    // Sticky error, set on the edge that loads the offending bundle into stage 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag_r <= 1'b0;
        end else if (s2_adv_s && s1_valid_r && (s1_flag_err_r || special_s)) begin
            err_flag_r <= 1'b1;
        end
    end

    assign err_flag = err_flag_r;
`endif

endmodule
